// File: rtl/mehrwort_addierer_steuerung.sv
// Multi-word adder controller: feeds an external combinational adder cell
// one chunk per cycle, LSB first, chaining the carry through a register.
module mehrwort_addierer_steuerung #(
    parameter int WIDTH = 10,
    parameter int WORDS = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic [WORDS*WIDTH-1:0] OP_A,
    input  logic [WORDS*WIDTH-1:0] OP_B,
    input  logic                   C_IN,
    output logic                   BUSY,
    output logic                   DONE,
    output logic [WORDS*WIDTH-1:0] SUM,
    output logic                   C_OUT,
    output logic [WIDTH-1:0]       ADD_A,
    output logic [WIDTH-1:0]       ADD_B,
    output logic                   ADD_C_IN,
    input  logic [WIDTH-1:0]       ADD_S,
    input  logic                   ADD_C_OUT
);

    localparam int N  = WORDS * WIDTH;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [N-1:0]   acc_q;
    logic [N-1:0]   acc_d;
    logic           carry_q;
    logic [IW-1:0]  idx_q;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic           run;
    logic           last;

    assign run  = (state_q == ST_RUN);
    assign last = (idx_q == LAST);
    assign BUSY = (state_q != ST_IDLE);
    assign DONE = (state_q == ST_DONE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (START) state_d = ST_RUN;
            ST_RUN:  if (last) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Chunk select and merge of the current adder result into the partial sum
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        acc_d = acc_q;
        for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IW'(i)) begin
                sel_a = a_q[i*WIDTH +: WIDTH];
                sel_b = b_q[i*WIDTH +: WIDTH];
                acc_d[i*WIDTH +: WIDTH] = ADD_S;
            end
        end
    end

    assign ADD_A    = run ? sel_a : '0;
    assign ADD_B    = run ? sel_b : '0;
    assign ADD_C_IN = run & carry_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            SUM     <= '0;
            C_OUT   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        a_q     <= OP_A;
                        b_q     <= OP_B;
                        carry_q <= C_IN;
                        acc_q   <= '0;
                        idx_q   <= '0;
                    end
                end
                ST_RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= ADD_C_OUT;
                    if (last) begin
                        idx_q <= '0;
                        SUM   <= acc_d;
                        C_OUT <= ADD_C_OUT;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mehrwort_addierer_steuerung.sv
// Bench for the multi-word adder controller: WIDTH=4/WORDS=3 and
// WIDTH=10/WORDS=1 instances, each wrapped around a behavioural adder cell.
module tb_mehrwort_addierer_steuerung;

    typedef struct {
        logic [11:0] a;
        logic [11:0] b;
        logic        cin;
        logic [11:0] s;
        logic        c;
    } vec_t;

    typedef struct packed {
        logic [11:0] s;
        logic        c;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start3;
    logic [11:0] opa3, opb3;
    logic        cin3;
    logic        busy3, done3;
    logic [11:0] sum3;
    logic        cout3;
    logic [3:0]  adda3, addb3, adds3;
    logic        addc3, addco3;

    logic        start1;
    logic [9:0]  opa1, opb1;
    logic        cin1;
    logic        busy1, done1;
    logic [9:0]  sum1;
    logic        cout1;
    logic [9:0]  adda1, addb1, adds1;
    logic        addc1, addco1;

    assign {addco3, adds3} = 5'(adda3) + 5'(addb3) + 5'(addc3);
    assign {addco1, adds1} = 11'(adda1) + 11'(addb1) + 11'(addc1);

    mehrwort_addierer_steuerung #(.WIDTH(4), .WORDS(3)) dut3 (
        .CLK(clk), .RST(rst), .START(start3),
        .OP_A(opa3), .OP_B(opb3), .C_IN(cin3),
        .BUSY(busy3), .DONE(done3), .SUM(sum3), .C_OUT(cout3),
        .ADD_A(adda3), .ADD_B(addb3), .ADD_C_IN(addc3),
        .ADD_S(adds3), .ADD_C_OUT(addco3)
    );

    mehrwort_addierer_steuerung #(.WIDTH(10), .WORDS(1)) dut1 (
        .CLK(clk), .RST(rst), .START(start1),
        .OP_A(opa1), .OP_B(opb1), .C_IN(cin1),
        .BUSY(busy1), .DONE(done1), .SUM(sum1), .C_OUT(cout1),
        .ADD_A(adda1), .ADD_B(addb1), .ADD_C_IN(addc1),
        .ADD_S(adds1), .ADD_C_OUT(addco1)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    res_t sb[$];
    res_t hold;
    logic mon_en = 1'b0;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard: results popped on DONE; SUM/C_OUT must hold otherwise
    always @(negedge clk) begin
        if (mon_en) begin
            if (done3) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_done", 32'(done3), 32'd0);
                end else begin
                    hold = sb.pop_front();
                    chk("sum3", 32'(sum3), 32'(hold.s));
                    chk("cout3", 32'(cout3), 32'(hold.c));
                end
            end else begin
                chk("sum3_hold", 32'(sum3), 32'(hold.s));
                chk("cout3_hold", 32'(cout3), 32'(hold.c));
            end
            if (!busy3 || done3)
                chk("add_idle", 32'({adda3, addb3, addc3}), 32'd0);
        end
    end

    task automatic issue3(input logic [11:0] a, input logic [11:0] b,
                          input logic ci, input logic [11:0] s,
                          input logic c);
        @(negedge clk);
        opa3   = a;
        opb3   = b;
        cin3   = ci;
        start3 = 1'b1;
        sb.push_back('{s: s, c: c});
        @(posedge clk);
        #1;
        start3 = 1'b0;
        opa3   = 12'($urandom);
        opb3   = 12'($urandom);
        cin3   = 1'($urandom);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("busy3_run", 32'(busy3), 32'd1);
            chk("done3_timing", 32'(done3), 32'(k == 4));
        end
        @(negedge clk);
        chk("busy3_idle", 32'(busy3), 32'd0);
        chk("done3_pulse", 32'(done3), 32'd0);
    endtask

    task automatic issue1(input logic [9:0] a, input logic [9:0] b,
                          input logic ci, input logic [9:0] s,
                          input logic c);
        @(negedge clk);
        opa1   = a;
        opb1   = b;
        cin1   = ci;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        opa1   = 10'($urandom);
        opb1   = 10'($urandom);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            chk("busy1_run", 32'(busy1), 32'd1);
            chk("done1_timing", 32'(done1), 32'(k == 2));
        end
        chk("sum1", 32'(sum1), 32'(s));
        chk("cout1", 32'(cout1), 32'(c));
        @(negedge clk);
        chk("busy1_idle", 32'(busy1), 32'd0);
        chk("sum1_hold", 32'(sum1), 32'(s));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [12:0] t;
        logic [11:0] ra, rb;
        logic        rc;

        tbl[0] = '{12'h0FF, 12'h001, 1'b0, 12'h100, 1'b0};
        tbl[1] = '{12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1};
        tbl[2] = '{12'h000, 12'h000, 1'b1, 12'h001, 1'b0};
        tbl[3] = '{12'hFFF, 12'hFFF, 1'b1, 12'hFFF, 1'b1};
        tbl[4] = '{12'hABC, 12'h123, 1'b0, 12'hBDF, 1'b0};
        tbl[5] = '{12'h800, 12'h800, 1'b0, 12'h000, 1'b1};
        tbl[6] = '{12'h0F0, 12'h010, 1'b1, 12'h101, 1'b0};
        tbl[7] = '{12'h00F, 12'h0F0, 1'b1, 12'h100, 1'b0};

        rst    = 1'b1;
        start3 = 1'b0;
        opa3   = '0;
        opb3   = '0;
        cin3   = 1'b0;
        start1 = 1'b0;
        opa1   = '0;
        opb1   = '0;
        cin1   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy3", 32'(busy3), 32'd0);
        chk("rst_done3", 32'(done3), 32'd0);
        chk("rst_sum3", 32'(sum3), 32'd0);
        chk("rst_cout3", 32'(cout3), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_sum1", 32'(sum1), 32'd0);
        hold   = '0;
        mon_en = 1'b1;

        for (int i = 0; i < 8; i++)
            issue3(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].c);

        for (int i = 0; i < 6; i++) begin
            ra = 12'($urandom);
            rb = 12'($urandom);
            rc = 1'($urandom);
            t  = {1'b0, ra} + {1'b0, rb} + 13'(rc);
            issue3(ra, rb, rc, t[11:0], t[12]);
        end

        // START held high: only operands present at IDLE edges count
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (c > 0)
                chk("done3_stream", 32'(done3), 32'((c % 5) == 4));
            ra     = 12'($urandom);
            rb     = 12'($urandom);
            rc     = 1'($urandom);
            opa3   = ra;
            opb3   = rb;
            cin3   = rc;
            start3 = 1'b1;
            if ((c % 5) == 0) begin
                t = {1'b0, ra} + {1'b0, rb} + 13'(rc);
                sb.push_back('{s: t[11:0], c: t[12]});
            end
        end
        @(negedge clk);
        chk("done3_stream_end", 32'(done3), 32'd0);
        start3 = 1'b0;

        // Reset in the middle of a run aborts it
        @(negedge clk);
        opa3   = 12'h555;
        opb3   = 12'h0AA;
        cin3   = 1'b1;
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst  = 1'b0;
        hold = '0;
        @(negedge clk);
        chk("abort_busy3", 32'(busy3), 32'd0);
        chk("abort_done3", 32'(done3), 32'd0);
        chk("abort_sum3", 32'(sum3), 32'd0);
        chk("abort_cout3", 32'(cout3), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done3), 32'd0);
        end
        issue3(12'h123, 12'h456, 1'b0, 12'h579, 1'b0);

        issue1(10'h3FF, 10'h001, 1'b0, 10'h000, 1'b1);
        issue1(10'h123, 10'h001, 1'b0, 10'h124, 1'b0);
        issue1(10'h200, 10'h1FF, 1'b1, 10'h000, 1'b1);
        issue1(10'h0AA, 10'h155, 1'b0, 10'h1FF, 1'b0);

        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
